// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - FIFO read port and payload stream bundle for uart_frame_parser
//
// Groups the two handshake buses of the frame parser:
//   FIFO read side : fifo_empty, fifo_rd_en, fifo_dout, fifo_valid
//   payload stream : out_data, out_valid, out_ready, out_last, out_len
// master = parser view, slave = environment (FIFO + downstream) view.

interface uart_frame_parser_if;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout;
  logic       fifo_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] out_len;

  modport master (
    input  fifo_empty, fifo_dout, fifo_valid, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last, out_len
  );

  modport slave (
    output fifo_empty, fifo_dout, fifo_valid, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last, out_len
  );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/LEN/payload/CHK frame parser behind the UART receive FIFO
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (master)      FIFO read handshake and buffered payload stream
//   status_valid      one-cycle pulse per frame outcome
//   status_code       0 OK, 1 bad LEN, 2 bad CHK, 3 timeout
//   ok_count          saturating count of good frames
//   err_count         saturating count of rejected frames

module uart_frame_parser #(
  parameter int unsigned CLK_IN        = 0,
  parameter int unsigned BAUD          = 0,
  parameter int unsigned MAX_LEN       = 64,
  parameter logic [7:0]  SOF_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_frame_parser_if.master    bus,
  output logic                   status_valid,
  output logic [1:0]             status_code,
  output logic [15:0]            ok_count,
  output logic [15:0]            err_count
);

  localparam int unsigned IW    = $clog2(MAX_LEN + 1);
  localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH = 1 << AW;

  // Timeout in clock cycles; a zero result (e.g. BAUD left at 0) disables the timeout.
  localparam logic [63:0] TMO_CALC  = (BAUD == 0) ? 64'd0 :
                                      (64'(TIMEOUT_CHARS) * 64'd10 * 64'(CLK_IN)) / 64'(BAUD);
  localparam logic [31:0] TMO_LIMIT = (TMO_CALC > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF
                                                                           : TMO_CALC[31:0];
  localparam bit          TMO_EN    = (TMO_LIMIT != 32'd0);

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_BADLEN = 2'd1;
  localparam logic [1:0] ST_BADCHK = 2'd2;
  localparam logic [1:0] ST_TMO    = 2'd3;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_EMIT} state_t;

  state_t          state, state_nx;
  logic            rd_en_q, rd_pend;
  logic [7:0]      len_q, sum_q;
  logic [IW-1:0]   idx_q, rd_idx_q;
  logic [31:0]     tmo_cnt;
  logic [15:0]     ok_cnt_q, err_cnt_q;
  logic [7:0]      buf_mem [DEPTH];

  logic            consume, in_frame, tmo_fire, bad_len, pl_last, emit_last, xfer, rd_issue;
  logic            ev_ok, ev_badlen, ev_badchk, ev_tmo, ev_err;
  logic [7:0]      byte_in;

  // A byte counts only when it answers our own outstanding read.
  assign byte_in   = bus.fifo_dout;
  assign consume   = rd_pend && bus.fifo_valid;
  assign in_frame  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_fire  = TMO_EN && in_frame && !consume && (tmo_cnt >= TMO_LIMIT);
  assign bad_len   = (byte_in == 8'd0) || (byte_in > 8'(MAX_LEN));
  assign pl_last   = (8'(idx_q) == len_q - 8'd1);
  assign emit_last = (8'(rd_idx_q) == len_q - 8'd1);
  assign xfer      = (state == S_EMIT) && bus.out_ready;
  assign rd_issue  = !bus.fifo_empty && !rd_pend && (state != S_EMIT);
  assign ev_err    = ev_badlen || ev_badchk || ev_tmo;
  assign ok_count  = ok_cnt_q;
  assign err_count = err_cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_HUNT:    if (consume && byte_in == SOF_BYTE) state_nx = S_LEN;
      S_LEN:     if (consume)  state_nx = bad_len ? S_HUNT : S_PAYLOAD;
                 else if (tmo_fire) state_nx = S_HUNT;
      S_PAYLOAD: if (consume && pl_last) state_nx = S_CHK;
                 else if (tmo_fire) state_nx = S_HUNT;
      S_CHK:     if (consume)  state_nx = (byte_in == sum_q) ? S_EMIT : S_HUNT;
                 else if (tmo_fire) state_nx = S_HUNT;
      S_EMIT:    if (xfer && emit_last) state_nx = S_HUNT;
      default:   state_nx = S_HUNT;
    endcase
  end

  // Outputs and frame outcome events
  always_comb begin
    bus.fifo_rd_en = rd_en_q;
    bus.out_valid  = 1'b0;
    bus.out_data   = 8'd0;
    bus.out_last   = 1'b0;
    bus.out_len    = 8'd0;
    ev_ok          = 1'b0;
    ev_badlen      = 1'b0;
    ev_badchk      = 1'b0;
    ev_tmo         = 1'b0;
    case (state)
      S_LEN: begin
        ev_badlen = consume && bad_len;
        ev_tmo    = tmo_fire;
      end
      S_PAYLOAD: ev_tmo = tmo_fire;
      S_CHK: begin
        ev_badchk = consume && (byte_in != sum_q);
        ev_tmo    = tmo_fire;
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = buf_mem[rd_idx_q[AW-1:0]];
        bus.out_last  = emit_last;
        bus.out_len   = len_q;
        ev_ok         = xfer && emit_last;
      end
      default: ;
    endcase
  end

  // Datapath, read handshake, status and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q      <= 1'b0;
      rd_pend      <= 1'b0;
      len_q        <= 8'd0;
      sum_q        <= 8'd0;
      idx_q        <= '0;
      rd_idx_q     <= '0;
      tmo_cnt      <= 32'd0;
      status_valid <= 1'b0;
      status_code  <= 2'd0;
      ok_cnt_q     <= 16'd0;
      err_cnt_q    <= 16'd0;
    end else begin
      rd_en_q <= rd_issue;
      if (rd_issue)     rd_pend <= 1'b1;
      else if (consume) rd_pend <= 1'b0;

      if (consume || !in_frame) tmo_cnt <= 32'd0;
      else                      tmo_cnt <= tmo_cnt + 32'd1;

      if (consume) begin
        case (state)
          S_LEN: begin
            len_q <= byte_in;
            sum_q <= byte_in;
            idx_q <= '0;
          end
          S_PAYLOAD: begin
            sum_q <= sum_q + byte_in;
            idx_q <= idx_q + 1'b1;
          end
          S_CHK:   rd_idx_q <= '0;
          default: ;
        endcase
      end
      if (xfer) rd_idx_q <= rd_idx_q + 1'b1;

      status_valid <= ev_ok || ev_err;
      status_code  <= ev_tmo ? ST_TMO : ev_badchk ? ST_BADCHK : ev_badlen ? ST_BADLEN : ST_OK;
      if (ev_ok  && ok_cnt_q  != 16'hFFFF) ok_cnt_q  <= ok_cnt_q + 16'd1;
      if (ev_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  // Payload buffer; contents are irrelevant after reset so it carries none.
  always_ff @(posedge clk) begin
    if (consume && state == S_PAYLOAD) buf_mem[idx_q[AW-1:0]] <= byte_in;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - Directed self-checking bench for uart_frame_parser

module tb_uart_frame_parser;
  localparam int unsigned CLK_IN    = 1000;
  localparam int unsigned BAUD      = 100;
  localparam int unsigned MAX_LEN   = 64;
  localparam int unsigned TMO_CHARS = 4;   // 400-cycle timeout

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_parser_if bus();
  logic        status_valid;
  logic [1:0]  status_code;
  logic [15:0] ok_count, err_count;

  uart_frame_parser #(
    .CLK_IN(CLK_IN), .BAUD(BAUD), .MAX_LEN(MAX_LEN),
    .SOF_BYTE(8'hA5), .TIMEOUT_CHARS(TMO_CHARS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .status_valid(status_valid), .status_code(status_code),
    .ok_count(ok_count), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  // FIFO model: one-cycle read latency
  logic [7:0] fq[$];
  logic       fe, fv;
  logic [7:0] fd;
  logic       rdy = 1'b1;
  assign bus.fifo_empty = fe;
  assign bus.fifo_valid = fv;
  assign bus.fifo_dout  = fd;
  assign bus.out_ready  = rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv <= 1'b0; fd <= 8'd0; fe <= 1'b1;
    end else begin
      fv <= 1'b0;
      if (bus.fifo_rd_en && fq.size() > 0) begin
        fd <= fq.pop_front();
        fv <= 1'b1;
      end
      fe <= (fq.size() == 0);
    end
  end

  int ready_mode = 0;
  int rcnt = 0;
  always @(posedge clk) begin
    #1;
    rcnt++;
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       rdy = (rcnt % 3 == 0);
      default: rdy = 1'b0;
    endcase
  end

  // Capture monitor
  logic [7:0] cap_data[$];
  logic       cap_last[$];
  logic [7:0] cap_len[$];
  logic [1:0] stat_q[$];
  int         stall_err = 0, rdemit_err = 0, emit_cycles = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) emit_cycles++;
      if (prev_stall && bus.out_valid && bus.out_data !== prev_data) stall_err++;
      if (bus.out_valid && bus.fifo_rd_en) rdemit_err++;
      if (bus.out_valid && bus.out_ready) begin
        cap_data.push_back(bus.out_data);
        cap_last.push_back(bus.out_last);
        cap_len.push_back(bus.out_len);
      end
      if (status_valid) stat_q.push_back(status_code);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  logic [7:0] stim[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  task automatic clear_caps;
    cap_data.delete(); cap_last.delete(); cap_len.delete(); stat_q.delete();
    stall_err = 0; rdemit_err = 0; emit_cycles = 0;
  endtask

  task automatic send;
    foreach (stim[i]) fq.push_back(stim[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    wait_cycles(3);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", bus.fifo_rd_en); end
    checks++; if (status_valid !== 1'b0) begin errors++; $display("FAIL reset_status got %b exp 0", status_valid); end
    checks++; if (ok_count !== 16'd0 || err_count !== 16'd0) begin errors++; $display("FAIL reset_counts got %h/%h exp 0/0", ok_count, err_count); end
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_good;
    clear_caps();
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send();
    wait_cycles(100);
    exp_data = '{8'h11, 8'h22, 8'h33}; exp_last = '{1'b0, 1'b0, 1'b1};
    checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL good_count got %0d exp 3", cap_data.size()); end
    for (int i = 0; i < cap_data.size() && i < 3; i++) begin
      checks++; if (cap_data[i] !== exp_data[i]) begin errors++; $display("FAIL good_data[%0d] got %h exp %h", i, cap_data[i], exp_data[i]); end
      checks++; if (cap_last[i] !== exp_last[i]) begin errors++; $display("FAIL good_last[%0d] got %b exp %b", i, cap_last[i], exp_last[i]); end
      checks++; if (cap_len[i] !== 8'd3) begin errors++; $display("FAIL good_len[%0d] got %h exp 03", i, cap_len[i]); end
    end
    checks++; if (stat_q.size() != 1 || stat_q[0] !== 2'd0) begin errors++; $display("FAIL good_status got n=%0d exp one code 0", stat_q.size()); end
    checks++; if (ok_count !== 16'd1 || err_count !== 16'd0) begin errors++; $display("FAIL good_counts got %0d/%0d exp 1/0", ok_count, err_count); end
  endtask

  task automatic test_bad_chk;
    clear_caps();
    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31}; send();
    wait_cycles(100);
    checks++; if (cap_data.size() != 0) begin errors++; $display("FAIL badchk_emit got %0d bytes exp 0", cap_data.size()); end
    checks++; if (stat_q.size() != 1 || stat_q[0] !== 2'd2) begin errors++; $display("FAIL badchk_status got n=%0d exp one code 2", stat_q.size()); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL badchk_err got %0d exp 1", err_count); end
    clear_caps();
    stim = '{8'hA5, 8'h01, 8'h7F, 8'h80}; send();
    wait_cycles(100);
    checks++; if (cap_data.size() != 1 || cap_data[0] !== 8'h7F) begin errors++; $display("FAIL badchk_follow got n=%0d exp one 7f", cap_data.size()); end
    checks++; if (ok_count !== 16'd2) begin errors++; $display("FAIL badchk_ok got %0d exp 2", ok_count); end
  endtask

  task automatic test_bad_len;
    clear_caps();
    stim = '{8'hA5, 8'h00, 8'hA5, 8'h41, 8'hA5, 8'h01, 8'h55, 8'h56}; send();
    wait_cycles(150);
    checks++; if (stat_q.size() != 3 || stat_q[0] !== 2'd1 || stat_q[1] !== 2'd1 || stat_q[2] !== 2'd0)
      begin errors++; $display("FAIL badlen_status got n=%0d exp codes 1,1,0", stat_q.size()); end
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL badlen_err got %0d exp 3", err_count); end
    checks++; if (cap_data.size() != 1 || cap_data[0] !== 8'h55) begin errors++; $display("FAIL badlen_resync got n=%0d exp one 55", cap_data.size()); end
    checks++; if (ok_count !== 16'd3) begin errors++; $display("FAIL badlen_ok got %0d exp 3", ok_count); end
  endtask

  task automatic test_backpressure;
    clear_caps();
    ready_mode = 1;
    stim = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E, 8'h00}; send();
    wait_cycles(150);
    ready_mode = 0;
    exp_data = '{8'h01, 8'h02, 8'h03, 8'h04}; exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    checks++; if (cap_data.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", cap_data.size()); end
    for (int i = 0; i < cap_data.size() && i < 4; i++) begin
      checks++; if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i] || cap_len[i] !== 8'd4)
        begin errors++; $display("FAIL bp_byte[%0d] got %h/%b/%h exp %h/%b/04", i, cap_data[i], cap_last[i], cap_len[i], exp_data[i], exp_last[i]); end
    end
    checks++; if (emit_cycles < 10) begin errors++; $display("FAIL bp_stalls got %0d valid cycles exp >=10", emit_cycles); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stall_err); end
    checks++; if (rdemit_err != 0) begin errors++; $display("FAIL bp_rd_en got %0d reads exp 0", rdemit_err); end
    checks++; if (ok_count !== 16'd4) begin errors++; $display("FAIL bp_ok got %0d exp 4", ok_count); end
  endtask

  task automatic test_back_to_back;
    clear_caps();
    stim = '{8'hA5, 8'h01, 8'h10, 8'h11, 8'hA5, 8'h02, 8'h20, 8'h21, 8'h43}; send();
    wait_cycles(150);
    exp_data = '{8'h10, 8'h20, 8'h21}; exp_last = '{1'b1, 1'b0, 1'b1};
    checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", cap_data.size()); end
    for (int i = 0; i < cap_data.size() && i < 3; i++) begin
      checks++; if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i])
        begin errors++; $display("FAIL b2b_byte[%0d] got %h/%b exp %h/%b", i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]); end
    end
    checks++; if (stat_q.size() != 2 || stat_q[0] !== 2'd0 || stat_q[1] !== 2'd0) begin errors++; $display("FAIL b2b_status got n=%0d exp codes 0,0", stat_q.size()); end
    checks++; if (ok_count !== 16'd6) begin errors++; $display("FAIL b2b_ok got %0d exp 6", ok_count); end
  endtask

  task automatic test_timeout;
    clear_caps();
    stim = '{8'hA5, 8'h05, 8'h01}; send();
    wait_cycles(600);
    checks++; if (stat_q.size() != 1 || stat_q[0] !== 2'd3) begin errors++; $display("FAIL tmo_status got n=%0d exp one code 3", stat_q.size()); end
    checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL tmo_err got %0d exp 4", err_count); end
    clear_caps();
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hAA, 8'hAB}; send();
    wait_cycles(100);
    checks++; if (cap_data.size() != 1 || cap_data[0] !== 8'hAA) begin errors++; $display("FAIL tmo_resync got n=%0d exp one aa", cap_data.size()); end
    checks++; if (stat_q.size() != 1 || stat_q[0] !== 2'd0) begin errors++; $display("FAIL tmo_resync_status got n=%0d exp one code 0", stat_q.size()); end
    checks++; if (ok_count !== 16'd7 || err_count !== 16'd4) begin errors++; $display("FAIL tmo_counts got %0d/%0d exp 7/4", ok_count, err_count); end
  endtask

  task automatic test_reset_emit;
    bit seen = 1'b0;
    clear_caps();
    ready_mode = 2;
    stim = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05}; send();
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_emit_reach got out_valid=0 exp 1 within 200 cycles"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_last !== 1'b0 || bus.out_len !== 8'd0)
      begin errors++; $display("FAIL rst_emit_stream got %b/%h/%b/%h exp 0/00/0/00", bus.out_valid, bus.out_data, bus.out_last, bus.out_len); end
    checks++; if (ok_count !== 16'd0 || err_count !== 16'd0 || status_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0)
      begin errors++; $display("FAIL rst_emit_misc got %h/%h/%b/%b exp 0/0/0/0", ok_count, err_count, status_valid, bus.fifo_rd_en); end
    wait_cycles(3);
    fq.delete();
    ready_mode = 0;
    rst_n = 1'b1;
    wait_cycles(3);
  endtask

  task automatic test_saturation;
    clear_caps();
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt_q;
    @(negedge clk);
    checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_preload got %h exp ffff", err_count); end
    stim = '{8'hA5, 8'h00}; send();
    wait_cycles(60);
    checks++; if (stat_q.size() != 1 || stat_q[0] !== 2'd1) begin errors++; $display("FAIL sat_status got n=%0d exp one code 1", stat_q.size()); end
    checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_err got %h exp ffff", err_count); end
    checks++; if (ok_count !== 16'd0) begin errors++; $display("FAIL sat_ok got %h exp 0000", ok_count); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_chk();
    test_bad_len();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_emit();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Downstream consumer of the UART receiver's byte FIFO.
- Pulls bytes over the FIFO read interface (rd_en/empty/dout/valid) and hunts for framed packets of the form SOF, LEN, payload, CHK.
- Buffers each payload internally and releases it on a valid/ready byte stream only if the checksum matches.
- Reports per-frame status and keeps saturating good/bad frame counters.

Parameters:
- CLK_IN, 0, input clock frequency in Hz; same meaning as the receiver.
- BAUD, 0, line baud rate; the timeout base is 10*CLK_IN/BAUD cycles per character.
- MAX_LEN, 64, maximum payload length in bytes (1..255); sets the internal buffer depth.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CHARS, 4, inter-byte gap in character times that aborts a frame in progress.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  receiver FIFO empty.
- fifo_rd_en  out  1  single-cycle read strobe to the FIFO.
- fifo_dout  in  8  FIFO read data.
- fifo_valid  in  1  fifo_dout holds the byte from the previous read.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  marks the final payload byte of the frame.
- out_len  out  8  LEN of the frame being emitted; stable for the whole emission.
- status_valid  out  1  one-cycle status pulse.
- status_code  out  2  0=OK, 1=bad LEN, 2=bad CHK, 3=timeout; valid with status_valid.
- ok_count  out  16  good frames, saturates at 16'hFFFF.
- err_count  out  16  bad frames of any kind, saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0): every output goes to 0, state=HUNT, no read outstanding, timeout counter=0. The buffer contents are don't-care. Reset during EMIT drops out_valid immediately and the frame is lost.
- FIFO read handshake:
  - fifo_rd_en is pulsed for exactly one cycle when fifo_empty=0, no read is outstanding, and state≠EMIT.
  - The parser then waits for fifo_valid=1 and consumes fifo_dout on that cycle. A new rd_en may be issued the following cycle.
  - fifo_valid with no outstanding read is ignored.
- States:
  - HUNT: consumed bytes ≠ SOF_BYTE are discarded silently. On SOF -> LEN.
  - LEN: the byte is stored as len and sum=byte. If len==0 or len>MAX_LEN: status 1, err_count+1, -> HUNT. Otherwise idx=0, -> PAYLOAD.
  - PAYLOAD: each byte is written to buf[idx], sum+=byte (mod 256), idx+1. After the len-th byte -> CHK. A byte equal to SOF_BYTE inside the payload is data; there is no resync.
  - CHK: if byte==sum -> EMIT, rd_idx=0. Otherwise status 2, err_count+1, -> HUNT.
  - EMIT:
    - out_valid=1, out_data=buf[rd_idx], out_len=len, out_last=(rd_idx==len-1).
    - A transfer occurs on out_valid&&out_ready; the next byte is presented the next cycle. out_valid may stay high back-to-back.
    - out_data must not change while out_valid=1 and out_ready=0.
    - After the last transfer: out_valid=0, status 0 pulse, ok_count+1, -> HUNT.
    - No FIFO reads occur during EMIT; the FIFO absorbs the incoming stream.
- Timeout:
  - In LEN, PAYLOAD and CHK, a counter increments every cycle and clears on each consumed byte.
  - Reaching TIMEOUT_CHARS*10*CLK_IN/BAUD gives status 3, err_count+1, -> HUNT.
  - If a byte is consumed in the same cycle as expiry, the byte wins and the timeout does not fire.
  - No timeout in HUNT or EMIT.
- status_valid is high for exactly one cycle per frame outcome and is never asserted in the same cycle as another status.
- Counters saturate; they do not wrap.
- Arithmetic: sum is 8-bit modulo 256. idx and rd_idx are sized to $clog2(MAX_LEN+1). The timeout counter is 32-bit.

Test Plan:
- Good frame: bytes A5 03 11 22 33 69 with out_ready=1 -> out_data 11,22,33 on consecutive valid cycles, out_last on 33, out_len=3, status_valid with code 0, ok_count=1.
- Bad checksum: A5 02 10 20 31 -> no out_valid, status code 2, err_count=1. A following good frame A5 01 7F 80 -> emits 7F, ok_count=1.
- Bad length: A5 00, and separately A5 41 with MAX_LEN=64 -> status code 1 each time, err_count=2, parser resynchronises on the next A5.
- Backpressure: good frame of length 4, out_ready toggling 1,0,0,1... -> each byte held stable while stalled, no duplicates or drops, fifo_rd_en stays 0 throughout EMIT.
- Timeout: A5 05 01 followed by silence for more than TIMEOUT_CHARS character times -> status code 3, state HUNT. Garbage bytes 00 FF then A5 01 AA AB -> AA emitted.
- Reset mid-EMIT and saturation: assert rst_n=0 while out_valid=1 -> all outputs 0 asynchronously. Preload err_count to FFFF, then one bad frame -> stays FFFF.
